// File: rtl/mux_scan_sequencer.sv
// Scans every input of a 4:1-style mux: drives select/enable, waits a settle time per channel,
// samples Y into a shadow register and hands the assembled word off over valid/ready.
module mux_scan_sequencer #(
    parameter int unsigned SEL_W         = 2,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  continuous_i,
    input  logic                  mux_y_i,
    output logic [SEL_W-1:0]      mux_s_o,
    output logic                  mux_e_o,
    output logic [(2**SEL_W)-1:0] data_out_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  busy_o
);

    localparam int unsigned NumCh = 2 ** SEL_W;
    localparam int unsigned CntW  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [CntW-1:0]  CntReload = CntW'(SETTLE_CYCLES);
    localparam logic [SEL_W-1:0] LastCh    = SEL_W'(NumCh - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               en_q, en_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [NumCh-1:0]   shadow_q, shadow_d;
    logic [NumCh-1:0]   data_q, data_d;
    logic               valid_q, valid_d;

    // State and datapath registers; async reset clears everything including the partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            en_q     <= 1'b0;
            cnt_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state logic: step channels, sample after settle, publish the word on the last channel.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        en_d     = en_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StSettle;
                    en_d    = 1'b1;
                    sel_d   = '0;
                    cnt_d   = CntReload;
                end
            end
            StSettle: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    shadow_d[sel_q] = mux_y_i;
                    if (sel_q != LastCh) begin
                        sel_d = sel_q + SEL_W'(1);
                        cnt_d = CntReload;
                    end else begin
                        // Publish the shadow with the final bit merged so no partial word shows.
                        state_d = StDone;
                        data_d  = shadow_d;
                        valid_d = 1'b1;
                    end
                end
            end
            StDone: begin
                if (data_ready_i) begin
                    valid_d = 1'b0;
                    sel_d   = '0;
                    if (continuous_i) begin
                        state_d = StSettle;
                        cnt_d   = CntReload;
                    end else begin
                        state_d = StIdle;
                        en_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mux_s_o      = sel_q;
    assign mux_e_o      = en_q;
    assign data_out_o   = data_q;
    assign data_valid_o = valid_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (settle 1 and settle 0), each driving a mux model.
// Expected words go into per-instance queues; monitors pop them at every handshake.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;

    // Instance A: SETTLE_CYCLES = 1
    logic       start_a, cont_a, ready_a, y_a, e_a, valid_a, busy_a;
    logic [1:0] s_a;
    logic [3:0] d_a, in_a;

    // Instance B: SETTLE_CYCLES = 0
    logic       start_b, cont_b, ready_b, y_b, e_b, valid_b, busy_b;
    logic [1:0] s_b;
    logic [3:0] d_b, in_b;

    int checks = 0;
    int errors = 0;

    logic [3:0] q_a[$];
    logic [3:0] q_b[$];

    always #5 clk = ~clk;

    // Mux models: Y = E ? I[S] : 0
    assign y_a = e_a ? in_a[s_a] : 1'b0;
    assign y_b = e_b ? in_b[s_b] : 1'b0;

    mux_scan_sequencer #(.SEL_W(2), .SETTLE_CYCLES(1)) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_a),
        .continuous_i (cont_a),
        .mux_y_i      (y_a),
        .mux_s_o      (s_a),
        .mux_e_o      (e_a),
        .data_out_o   (d_a),
        .data_valid_o (valid_a),
        .data_ready_i (ready_a),
        .busy_o       (busy_a)
    );

    mux_scan_sequencer #(.SEL_W(2), .SETTLE_CYCLES(0)) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_b),
        .continuous_i (cont_b),
        .mux_y_i      (y_b),
        .mux_s_o      (s_b),
        .mux_e_o      (e_b),
        .data_out_o   (d_b),
        .data_valid_o (valid_b),
        .data_ready_i (ready_b),
        .busy_o       (busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop and compare on every handshake, sampled between edges.
    always @(negedge clk) begin
        #2;
        if (valid_a === 1'b1 && ready_a === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_a: got unexpected word %0h expected none", d_a);
            end else begin
                chk("word_a", 32'(d_a), 32'(q_a.pop_front()));
            end
        end
        if (valid_b === 1'b1 && ready_b === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_b: got unexpected word %0h expected none", d_b);
            end else begin
                chk("word_b", 32'(d_b), 32'(q_b.pop_front()));
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the start edge t0.
    task automatic pulse_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {start_a, cont_a, ready_a} = 3'b000;
        {start_b, cont_b, ready_b} = 3'b000;
        in_a = 4'b0000;
        in_b = 4'b0000;

        // 1. Reset values
        #1;
        chk("rst_s", 32'(s_a), 0);
        chk("rst_e", 32'(e_a), 0);
        chk("rst_data", 32'(d_a), 0);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_busy_b", 32'(busy_b), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2. Single scan, ready always high
        in_a    = 4'b0101;
        ready_a = 1'b1;
        q_a.push_back(4'b0101);
        pulse_a();
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("t2_sel_j%0d", j), 32'(s_a), 32'(j / 2));
            chk($sformatf("t2_busy_j%0d", j), 32'(busy_a), 1);
            chk($sformatf("t2_novalid_j%0d", j), 32'(valid_a), 0);
            @(negedge clk);
        end
        chk("t2_valid", 32'(valid_a), 1);
        chk("t2_data", 32'(d_a), 32'h5);
        chk("t2_sel_done", 32'(s_a), 3);
        @(negedge clk);
        chk("t2_valid_drop", 32'(valid_a), 0);
        chk("t2_e_off", 32'(e_a), 0);
        chk("t2_idle", 32'(busy_a), 0);
        chk("t2_sel0", 32'(s_a), 0);
        chk("t2_data_kept", 32'(d_a), 32'h5);
        @(negedge clk);

        // 3. Backpressure for 5 cycles
        ready_a = 1'b0;
        in_a    = 4'b0101;
        q_a.push_back(4'b0101);
        pulse_a();
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_valid_%0d", i), 32'(valid_a), 1);
            chk($sformatf("t3_data_%0d", i), 32'(d_a), 32'h5);
            chk($sformatf("t3_sel_%0d", i), 32'(s_a), 3);
            chk($sformatf("t3_e_%0d", i), 32'(e_a), 1);
            @(negedge clk);
        end
        ready_a = 1'b1;
        @(negedge clk);
        chk("t3_valid_drop", 32'(valid_a), 0);
        chk("t3_idle", 32'(busy_a), 0);
        @(negedge clk);

        // 4. Continuous: two words, busy throughout
        cont_a = 1'b1;
        in_a   = 4'b0101;
        q_a.push_back(4'b0101);
        q_a.push_back(4'b1010);
        pulse_a();
        for (int j = 0; j < 18; j++) begin
            chk($sformatf("t4_busy_j%0d", j), 32'(busy_a), 1);
            if (j == 8) begin
                chk("t4_valid1", 32'(valid_a), 1);
                in_a = 4'b1010;
            end
            if (j == 9) begin
                chk("t4_sel_wrap", 32'(s_a), 0);
                chk("t4_valid_low", 32'(valid_a), 0);
                chk("t4_data_old", 32'(d_a), 32'h5);
            end
            if (j == 17) begin
                chk("t4_valid2", 32'(valid_a), 1);
                chk("t4_data2", 32'(d_a), 32'hA);
                cont_a = 1'b0;
            end
            @(negedge clk);
        end
        chk("t4_idle", 32'(busy_a), 0);
        chk("t4_e_off", 32'(e_a), 0);
        @(negedge clk);

        // 5. Async reset mid-scan at mux_s = 2, then a clean rescan
        in_a = 4'b1111;
        pulse_a();
        repeat (4) @(negedge clk);
        chk("t5_sel2", 32'(s_a), 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_s", 32'(s_a), 0);
        chk("t5_rst_e", 32'(e_a), 0);
        chk("t5_rst_data", 32'(d_a), 0);
        chk("t5_rst_valid", 32'(valid_a), 0);
        chk("t5_rst_busy", 32'(busy_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t5_nopulse_%0d", i), 32'(valid_a), 0);
        end
        in_a = 4'b0101;
        q_a.push_back(4'b0101);
        pulse_a();
        repeat (8) @(negedge clk);
        chk("t5_valid", 32'(valid_a), 1);
        chk("t5_data", 32'(d_a), 32'h5);
        @(negedge clk);
        chk("t5_idle", 32'(busy_a), 0);

        // 6. SETTLE_CYCLES = 0, start held high while busy
        in_b    = 4'b0110;
        ready_b = 1'b1;
        q_b.push_back(4'b0110);
        start_b = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t6_sel_j%0d", j), 32'(s_b), 32'(j));
            chk($sformatf("t6_novalid_j%0d", j), 32'(valid_b), 0);
            @(negedge clk);
        end
        chk("t6_valid", 32'(valid_b), 1);
        chk("t6_data", 32'(d_b), 32'h6);
        start_b = 1'b0;
        @(negedge clk);
        chk("t6_idle", 32'(busy_b), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t6_single_%0d", i), 32'(valid_b), 0);
        end

        @(negedge clk);
        chk("q_a_empty", 32'(q_a.size()), 0);
        chk("q_b_empty", 32'(q_b.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
